// File: rtl/mtm_alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// mtm_alu_sequencer_if
// Bundle of every non-clock/reset signal of mtm_alu_sequencer.
//   byte input side : in_valid, in_data, in_is_cmd -> sequencer; in_ready <- sequencer
//   core side       : core_a, core_b, core_op, core_err, core_dr, core_rst_n
//                     <- sequencer; core_c, core_ctl -> sequencer
//   result side     : res_valid, res_c, res_ctl, res_is_err <- sequencer;
//                     res_ready -> sequencer
//   debug           : seq_state, current FSM state of the sequencer
// Handshakes: a byte is taken on a rising edge with in_valid & in_ready
// (bytes offered while in_ready = 0 are lost); a result is taken on a rising
// edge with res_valid & res_ready, and res_* hold still until then.
// modport slave  : the sequencer view
// modport master : the environment view (deserializer, core, serializer)
// ---------------------------------------------------------------------------
interface mtm_alu_sequencer_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_is_cmd;
   logic        in_ready;
   logic [32:0] core_a;
   logic [32:0] core_b;
   logic [2:0]  core_op;
   logic [6:0]  core_err;
   logic        core_dr;
   logic        core_rst_n;
   logic [32:0] core_c;
   logic [7:0]  core_ctl;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_c;
   logic [7:0]  res_ctl;
   logic        res_is_err;
   logic [1:0]  seq_state;

   modport slave (
      input  in_valid, in_data, in_is_cmd, core_c, core_ctl, res_ready,
      output in_ready, core_a, core_b, core_op, core_err, core_dr, core_rst_n,
             res_valid, res_c, res_ctl, res_is_err, seq_state
   );

   modport master (
      output in_valid, in_data, in_is_cmd, core_c, core_ctl, res_ready,
      input  in_ready, core_a, core_b, core_op, core_err, core_dr, core_rst_n,
             res_valid, res_c, res_ctl, res_is_err, seq_state
   );
endinterface

// File: rtl/mtm_alu_sequencer.sv
// ---------------------------------------------------------------------------
// mtm_alu_sequencer
// Frame controller between the byte deserializer and mtm_Alu_core.
// Collects 8 data bytes (B first, then A, MSB first) and a command byte
// {x, OP[2:0], CRC[3:0]}, checks the frame, drives A/B/OP/err_flags to the
// core with a one-cycle data_ready pulse, captures C/CTL and offers them to
// the serializer.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mtm_alu_sequencer_if.slave (byte input, core side, result side)
// Optional feature: define MTM_SEQ_CRC_CHECK_EN to check the CRC4 field of
// the command byte; when undefined the CRC field is ignored and ce = 0.
// ---------------------------------------------------------------------------
module mtm_alu_sequencer #(
   parameter int DATA_BYTES = 8,
   parameter int OP_W       = 3
) (
   input logic                 clk,
   input logic                 rst,
   mtm_alu_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      START   = 2'd1,
      CAPTURE = 2'd2,
      OUTPUT  = 2'd3
   } state_t;

   state_t      state;
   logic [63:0] ba;       // {B, A} once a full frame has been shifted in
   logic [3:0]  cnt;
   logic        ovf;

   logic [OP_W-1:0] cmd_op;
   logic            de, ce, oe;
   logic [6:0]      err_flags;

   assign cmd_op = bus.in_data[4 +: OP_W];

   // A wrong byte count masks the CRC and opcode checks.
   assign de = (cnt != 4'(DATA_BYTES)) | ovf;

`ifdef MTM_SEQ_CRC_CHECK_EN
   // CRC4, poly x^4+x+1, init 0, bit-serial MSB first.
   function automatic logic [3:0] crc4(input logic [67:0] d);
      logic [3:0] c;
      logic       fb;
      c = '0;
      for (int i = 67; i >= 0; i--) begin
         fb = c[3] ^ d[i];
         c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
      end
      return c;
   endfunction

   assign ce = ~de & (crc4({ba, 1'b1, cmd_op}) != bus.in_data[3:0]);

   logic unused_bits;
   assign unused_bits = ^{bus.in_data[7], bus.core_c[32]};
`else
   assign ce = 1'b0;

   logic unused_bits;
   assign unused_bits = ^{bus.in_data[7], bus.in_data[3:0], bus.core_c[32]};
`endif

   assign oe = ~de & ~(cmd_op inside {3'b000, 3'b001, 3'b100, 3'b101});

   assign err_flags = (de | ce | oe) ? {1'b1, de, ce, oe, de, ce, oe} : 7'd0;

   assign bus.core_rst_n = ~rst;
   assign bus.seq_state  = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= COLLECT;
         ba             <= '0;
         cnt            <= '0;
         ovf            <= 1'b0;
         bus.in_ready   <= 1'b0;
         bus.core_a     <= '0;
         bus.core_b     <= '0;
         bus.core_op    <= '0;
         bus.core_err   <= '0;
         bus.core_dr    <= 1'b0;
         bus.res_valid  <= 1'b0;
         bus.res_c      <= '0;
         bus.res_ctl    <= '0;
         bus.res_is_err <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               // in_ready comes up one cycle after reset release.
               bus.in_ready <= 1'b1;
               if (bus.in_valid && bus.in_ready) begin
                  if (bus.in_is_cmd) begin
                     // Core inputs settle together with the dr pulse and
                     // stay put until the next command.
                     bus.core_a   <= {1'b0, ba[31:0]};
                     bus.core_b   <= {1'b0, ba[63:32]};
                     bus.core_op  <= cmd_op;
                     bus.core_err <= err_flags;
                     bus.core_dr  <= 1'b1;
                     bus.in_ready <= 1'b0;
                     state        <= START;
                  end else begin
                     if (cnt < 4'(DATA_BYTES))
                        ba <= {ba[55:0], bus.in_data};
                     else
                        ovf <= 1'b1;
                     if (cnt != 4'hF)
                        cnt <= cnt + 4'd1;
                  end
               end
            end
            START: begin
               bus.core_dr <= 1'b0;
               state       <= CAPTURE;
            end
            CAPTURE: begin
               bus.res_c      <= bus.core_c[31:0];
               bus.res_ctl    <= bus.core_ctl;
               bus.res_is_err <= bus.core_err[6];
               bus.res_valid  <= 1'b1;
               state          <= OUTPUT;
            end
            OUTPUT: begin
               if (bus.res_ready) begin
                  bus.res_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  cnt           <= '0;
                  ovf           <= 1'b0;
                  state         <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule
